uart_rx_os: RTL
===============

# uart_rx_os

Oversampled UART receiver for the serial link: recovers 8N1 (optionally 8E1) frames from an asynchronous `serial_rx` line using a D-clocks-per-bit baud counter with mid-bit sampling. Presents each received byte on a valid/ready interface with framing, parity and overrun flags. Counterpart to the team's bit-per-clock transmitter path; sits between the board RX pin and the command/data consumer logic, clocked from the PLL output clock.

## Interface
- `N`, 8: data bits per frame, sent LSB first.
- `D`, 434: clock cycles per bit (50 MHz / 115200); must be ≥ 4.
- `clk`, input, 1: single clock; all logic on posedge.
- `rst`, input, 1: reset, synchronous, active-low.
- `serial_rx`, input, 1: asynchronous serial line, idle high.
- `rx_ready`, input, 1: consumer accepts `rx_data` when `rx_valid & rx_ready`.
- `rx_data`, output, N: last accepted frame payload.
- `rx_valid`, output, 1: `rx_data` holds an unconsumed byte.
- `frame_err`, output, 1: one-cycle pulse, stop bit sampled 0.
- `parity_err`, output, 1: one-cycle pulse, parity mismatch; constant 0 without `UART_RX_PARITY_EN`.
- `overrun`, output, 1: one-cycle pulse, good frame dropped because `rx_valid` was still high.
- `busy`, output, 1: high whenever state ≠ IDLE.

## Operation
- `serial_rx` passes through a 2-flop synchronizer (flops reset to 1); all decisions use synchronized `rxs`.
- States: IDLE, START, DATA, PARITY (only with macro), STOP, BREAK.
- IDLE: `rxs == 0` → START, baud counter cleared. Cycle of detection = t0.
- START: at t0 + D/2 (integer division) sample `rxs`; 1 → IDLE (glitch, no flags); 0 → DATA, bit counter 0.
- DATA: sample every D cycles, shift into bit k (LSB first); after bit N-1 → PARITY or STOP.
- PARITY: sample one bit D cycles later; even parity over data + parity bit must be 0, else flag held for STOP.
- STOP: sample D cycles later. 1 and no parity error → frame good → IDLE. 0 → `frame_err` pulse, frame discarded → BREAK. 1 with parity error → `parity_err` pulse, discarded → IDLE.
- BREAK: wait until `rxs == 1`, then IDLE (no repeated errors on a held-low line).
- Good frame with `rx_valid == 0`, or `rx_valid & rx_ready` in the same cycle: load `rx_data`, `rx_valid` = 1, no overrun.
- Good frame with `rx_valid == 1` and `rx_ready == 0`: `overrun` pulse, `rx_data` unchanged.
- `rx_valid & rx_ready` with no new frame: `rx_valid` → 0 next cycle.
- Baud counter width `$clog2(D)`; bit counter width `$clog2(N+1)`; counter wraps at D-1 → 0.

## Timing
- Reset (sync, `rst == 0` at posedge): state IDLE, counters 0, synchronizer 1, `rx_data` 0, `rx_valid` 0, all pulses 0, `busy` 0. Reset mid-frame aborts with no flags.
- Pin-to-`rxs` latency: 2 cycles.
- Sample of data bit k: t0 + D/2 + (k+1)·D. Parity: t0 + D/2 + (N+1)·D. Stop: t0 + D/2 + (N+1+P)·D, P = 1 with parity else 0.
- `rx_valid`/error pulses assert the cycle after the stop sample; state is IDLE that same cycle, so a new start can be detected on the following cycle.
- Error and overrun pulses last exactly one cycle.

## Configuration
- `UART_RX_PARITY_EN` defined: PARITY state present, even parity checked, frame length N+3 bits.
- Undefined: no PARITY state, frame N+2 bits, `parity_err` tied 0.

## Structure
- Package `uart_pkg`: `uart_rx_state_t` enum, `UART_IDLE_LEVEL = 1'b1`, default `N`/`D` constants shared with the transmitter.
- Sub-module `uart_sync`: 2-flop synchronizer with reset value parameter.

## Test plan
All with D = 16 for bench speed, plus one run at D = 434.
- Frame 0xA5 at D cycles/bit, `rx_ready` = 0 → `rx_valid` = 1 at t0 + 8 + 9·16 + 1, `rx_data` = 0xA5, no flags.
- Low glitch of 5 cycles on idle line → no `rx_valid`, no flags, `busy` returns 0 at t0 + 9.
- Frame 0x3C with stop bit 0, line held low 40 cycles → single `frame_err` pulse, `rx_valid` stays 0, next frame 0x01 received correctly.
- Frames 0x11 then 0x22, `rx_ready` = 0 → `overrun` pulse, `rx_data` = 0x11; repeat with `rx_ready` = 1 on the completion cycle → `rx_data` = 0x22, no overrun.
- Reset asserted mid-data-bit 4 of 0xFF → all outputs reset next edge; following frame 0x5A received intact.
- With `UART_RX_PARITY_EN`: 0x07 with parity bit 0 (wrong) → `parity_err` pulse, no `rx_valid`; with parity bit 1 → `rx_data` = 0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART receive and transmit paths.
//   UART_N          default data bits per frame
//   UART_D          default clock cycles per bit (50 MHz / 115200)
//   UART_IDLE_LEVEL line level while idle / during stop bit
//   uart_rx_state_t receiver FSM states (StParity only with UART_RX_PARITY_EN)
package uart_pkg;

   localparam int unsigned UART_N          = 8;
   localparam int unsigned UART_D          = 434;
   localparam logic        UART_IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
`ifdef UART_RX_PARITY_EN
      StParity,
`endif
      StStop,
      StBreak
   } uart_rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchronizer for an asynchronous single-bit input.
//   ResetVal  value both flops take during reset
//   clk       clock
//   rst       synchronous active-low reset
//   d         asynchronous input
//   q         synchronized output (2 cycles of latency)
module uart_sync #(
   parameter logic ResetVal = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         meta_q <= ResetVal;
         sync_q <= ResetVal;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampled UART receiver, 8N1 (8E1 when UART_RX_PARITY_EN is defined).
// Mid-bit sampling driven by a D-cycles-per-bit baud counter.
//   N          data bits per frame, LSB first
//   D          clock cycles per bit (>= 4)
//   clk        clock
//   rst        synchronous active-low reset
//   serial_rx  asynchronous serial line, idle high
//   rx_ready   consumer accepts rx_data when rx_valid & rx_ready
//   rx_data    last accepted payload
//   rx_valid   rx_data holds an unconsumed byte
//   frame_err  1-cycle pulse: stop bit sampled low
//   parity_err 1-cycle pulse: even parity mismatch (tied 0 without parity)
//   overrun    1-cycle pulse: good frame dropped, previous byte not yet consumed
//   busy       receiver not idle
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int unsigned N = UART_N,
   parameter int unsigned D = UART_D
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         serial_rx,
   input  logic         rx_ready,
   output logic [N-1:0] rx_data,
   output logic         rx_valid,
   output logic         frame_err,
   output logic         parity_err,
   output logic         overrun,
   output logic         busy
);

   localparam int unsigned CW = $clog2(D);
   localparam int unsigned BW = $clog2(N + 1);
   localparam logic [CW-1:0] CntLast = CW'(D - 1);
   // Start bit is checked half a bit in, so every later sample lands mid-bit.
   localparam logic [CW-1:0] CntHalf = CW'(D / 2 - 1);
   localparam logic [BW-1:0] BitLast = BW'(N - 1);

   logic rxs;

   uart_sync #(
      .ResetVal (UART_IDLE_LEVEL)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (serial_rx),
      .q   (rxs)
   );

   uart_rx_state_t state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [BW-1:0]  bit_q, bit_d;
   logic [N-1:0]   shift_q, shift_d;
   logic [N-1:0]   rx_data_q, rx_data_d;
   logic           rx_valid_q, rx_valid_d;
   logic           frame_err_q, frame_err_d;
   logic           overrun_q, overrun_d;
   logic           tick;
   logic           good;
`ifdef UART_RX_PARITY_EN
   logic           perr_q, perr_d;
   logic           parity_err_q, parity_err_d;
`endif

   assign tick = (cnt_q == CntLast);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
      good        = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d       = perr_q;
      parity_err_d = 1'b0;
`endif

      if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (rxs != UART_IDLE_LEVEL) begin
               state_d = StStart;
               cnt_d   = '0;
            end
         end
         StStart: begin
            if (cnt_q == CntHalf) begin
               cnt_d = '0;
               if (rxs == 1'b0) begin
                  state_d = StData;
                  bit_d   = '0;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StData: begin
            if (tick) begin
               cnt_d   = '0;
               shift_d = {rxs, shift_q[N-1:1]};
               if (bit_q == BitLast) begin
                  bit_d = '0;
`ifdef UART_RX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`ifdef UART_RX_PARITY_EN
         StParity: begin
            if (tick) begin
               cnt_d   = '0;
               perr_d  = ^{rxs, shift_q};
               state_d = StStop;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`endif
         StStop: begin
            if (tick) begin
               cnt_d = '0;
               if (rxs == 1'b0) begin
                  frame_err_d = 1'b1;
                  state_d     = StBreak;
`ifdef UART_RX_PARITY_EN
               end else if (perr_q) begin
                  parity_err_d = 1'b1;
                  state_d      = StIdle;
`endif
               end else begin
                  good    = 1'b1;
                  state_d = StIdle;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StBreak: begin
            // Hold here until the line recovers so a stuck-low line flags only once.
            if (rxs == UART_IDLE_LEVEL) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // A same-cycle pop frees the holding register, so the new byte is not an overrun.
      if (good) begin
         if (!rx_valid_q || rx_ready) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         perr_q       <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         perr_q       <= perr_d;
         parity_err_q <= parity_err_d;
      end
   end
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign busy      = (state_q != StIdle);

endmodule
